// File: rtl/mem_arbiter_if.sv
// Cache/RAM signal bundle for mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ramerr;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache.
// The dcache has priority, but an icache read is forced through after STARVE_LIMIT dcache completions.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic          CLK,
    input logic          RST,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;
    typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ram_state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t     state;
    ram_state_t ram_st;
    logic [2:0] starve_cnt;
    logic       ramerr_q;
    logic       d_req;
    logic       access;
    logic       error;
    logic       d_first;

    always_comb begin
        ram_st  = ram_state_t'(bus.ramstate);
        d_req   = bus.dREN | bus.dWEN;
        access  = (ram_st == RAM_ACCESS);
        error   = (ram_st == RAM_ERROR);
        // A saturated counter only blocks the dcache while the icache is actually waiting.
        d_first = d_req && ((starve_cnt < LIMIT) || !bus.iREN);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            ramerr_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (d_first)
                        state <= DGRANT;
                    else if (bus.iREN)
                        state <= IGRANT;
                end
                IGRANT: begin
                    if (access || error || !bus.iREN)
                        state <= IDLE;
                end
                DGRANT: begin
                    if (access || error || !d_req)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if ((state != IDLE) && error)
                ramerr_q <= 1'b1;

            if (!bus.iREN)
                starve_cnt <= '0;
            else if ((state == IGRANT) && access)
                starve_cnt <= '0;
            else if ((state == DGRANT) && access && (starve_cnt < LIMIT))
                starve_cnt <= starve_cnt + 3'd1;
        end
    end

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        unique case (state)
            IGRANT: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                bus.iwait   = !access;
            end
            DGRANT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.dwait    = !access;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.iload  = bus.ramload;
        bus.dload  = bus.ramload;
        bus.ramerr = ramerr_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter: cycle-by-cycle vectors plus hand-written reset sequences.
module tb_mem_arbiter;

    localparam logic [1:0] F = 2'd0;
    localparam logic [1:0] B = 2'd1;
    localparam logic [1:0] A = 2'd2;
    localparam logic [1:0] E = 2'd3;

    typedef struct {
        string       name;
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic [1:0]  rstate;
        logic [68:0] exp;   // {iwait, dwait, ramREN, ramWEN, ramerr, ramaddr, ramstore}
    } vec_t;

    logic CLK;
    logic RST;
    int unsigned n_checks;
    int unsigned n_fail;
    vec_t vecs[$];

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [68:0] outs();
        return {bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.ramerr, bus.ramaddr, bus.ramstore};
    endfunction

    function automatic logic [68:0] mk(logic iw, logic dw, logic ren, logic wen, logic err,
                                       logic [31:0] ra, logic [31:0] rs);
        return {iw, dw, ren, wen, err, ra, rs};
    endfunction

    task automatic check(string nm, logic [68:0] exp);
        logic [68:0] act;
        act = outs();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got iw=%b dw=%b ren=%b wen=%b err=%b addr=%h store=%h, expected iw=%b dw=%b ren=%b wen=%b err=%b addr=%h store=%h",
                     nm, act[68], act[67], act[66], act[65], act[64], act[63:32], act[31:0],
                     exp[68], exp[67], exp[66], exp[65], exp[64], exp[63:32], exp[31:0]);
        end
    endtask

    task automatic add(string nm, logic iren, logic [31:0] ia, logic dren, logic dwen,
                       logic [31:0] da, logic [31:0] ds, logic [1:0] rs, logic [68:0] exp);
        vec_t v;
        v.name = nm; v.iren = iren; v.iaddr = ia; v.dren = dren; v.dwen = dwen;
        v.daddr = da; v.dstore = ds; v.rstate = rs; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(logic iren, logic [31:0] ia, logic dren, logic dwen,
                         logic [31:0] da, logic [31:0] ds, logic [1:0] rs, logic [31:0] rl);
        bus.iREN = iren; bus.iaddr = ia; bus.dREN = dren; bus.dWEN = dwen;
        bus.daddr = da; bus.dstore = ds; bus.ramstate = rs; bus.ramload = rl;
    endtask

    initial begin
        logic [68:0] idle0;
        logic [68:0] idle1;
        logic [31:0] rl;
        n_checks = 0;
        n_fail   = 0;
        idle0 = mk(1, 1, 0, 0, 0, 32'h0, 32'h0);
        idle1 = mk(1, 1, 0, 0, 1, 32'h0, 32'h0);

        // Dcache write through two BUSY cycles.
        add("idle",       0, 0, 0, 0, 0, 0, F, idle0);
        add("wr_req",     0, 0, 0, 1, 32'h40, 32'hCAFE0001, F, idle0);
        add("wr_busy1",   0, 0, 0, 1, 32'h40, 32'hCAFE0001, B, mk(1, 1, 0, 1, 0, 32'h40, 32'hCAFE0001));
        add("wr_busy2",   0, 0, 0, 1, 32'h40, 32'hCAFE0001, B, mk(1, 1, 0, 1, 0, 32'h40, 32'hCAFE0001));
        add("wr_access",  0, 0, 0, 1, 32'h40, 32'hCAFE0001, A, mk(1, 0, 0, 1, 0, 32'h40, 32'hCAFE0001));
        add("wr_bubble",  0, 0, 0, 0, 0, 0, F, idle0);
        // Read and write together: write wins.
        add("rw_req",     0, 0, 1, 1, 32'h44, 32'h12345678, F, idle0);
        add("rw_access",  0, 0, 1, 1, 32'h44, 32'h12345678, A, mk(1, 0, 0, 1, 0, 32'h44, 32'h12345678));
        add("rw_idle",    0, 0, 0, 0, 0, 0, F, idle0);
        // Zero-wait dcache read.
        add("rd_req",     0, 0, 1, 0, 32'h48, 32'h0BAD0BAD, F, idle0);
        add("rd_access",  0, 0, 1, 0, 32'h48, 32'h0BAD0BAD, A, mk(1, 0, 1, 0, 0, 32'h48, 32'h0BAD0BAD));
        add("rd_idle",    0, 0, 0, 0, 0, 0, F, idle0);
        // Request dropped mid-BUSY.
        add("drop_req",   0, 0, 1, 0, 32'h4C, 0, F, idle0);
        add("drop_busy",  0, 0, 1, 0, 32'h4C, 0, B, mk(1, 1, 1, 0, 0, 32'h4C, 32'h0));
        add("drop_now",   0, 0, 0, 0, 32'h4C, 0, B, mk(1, 1, 0, 0, 0, 32'h4C, 32'h0));
        add("drop_idle",  0, 0, 0, 0, 32'h4C, 0, B, idle0);
        // Icache ERROR then retry.
        add("ierr_req",   1, 32'h100, 0, 0, 0, 0, F, idle0);
        add("ierr_err",   1, 32'h100, 0, 0, 0, 0, E, mk(1, 1, 1, 0, 0, 32'h100, 32'h0));
        add("ierr_retry", 1, 32'h100, 0, 0, 0, 0, F, idle1);
        add("ierr_acc",   1, 32'h100, 0, 0, 0, 0, A, mk(0, 1, 1, 0, 1, 32'h100, 32'h0));
        add("ierr_idle",  0, 0, 0, 0, 0, 0, F, idle1);
        // Both caches requesting against a zero-wait RAM: D,D,D,D,I,D.
        for (int g = 0; g < 6; g++) begin
            add($sformatf("starve_idle%0d", g), 1, 32'h100, 1, 0, 32'h200, 32'h55550000, A, idle1);
            if (g == 4)
                add("starve_igrant", 1, 32'h100, 1, 0, 32'h200, 32'h55550000, A,
                    mk(0, 1, 1, 0, 1, 32'h100, 32'h0));
            else
                add($sformatf("starve_dgrant%0d", g), 1, 32'h100, 1, 0, 32'h200, 32'h55550000, A,
                    mk(1, 0, 1, 0, 1, 32'h200, 32'h55550000));
        end
        add("final_idle", 0, 0, 0, 0, 0, 0, F, idle1);

        // Reset holds idle outputs even with requests and ACCESS present.
        RST = 1'b1;
        drive(1, 32'h100, 1, 1, 32'h200, 32'h1, A, 32'h0);
        repeat (2) @(posedge CLK);
        #1 check("reset_hold", idle0);
        drive(0, 0, 0, 0, 0, 0, F, 0);
        RST = 1'b0;

        foreach (vecs[i]) begin
            @(posedge CLK);
            #1;
            rl = 32'hD000_0000 | 32'(i);
            drive(vecs[i].iren, vecs[i].iaddr, vecs[i].dren, vecs[i].dwen,
                  vecs[i].daddr, vecs[i].dstore, vecs[i].rstate, rl);
            #4;
            check(vecs[i].name, vecs[i].exp);
            n_checks++;
            if (bus.iload !== rl || bus.dload !== rl) begin
                n_fail++;
                $display("FAIL %s_load: got iload=%h dload=%h, expected %h", vecs[i].name, bus.iload, bus.dload, rl);
            end
        end

        // Reset pulsed during a dcache BUSY cycle aborts without a dwait pulse.
        @(posedge CLK);
        #1 drive(0, 0, 1, 0, 32'h300, 32'h0, B, 0);
        #4 check("rst_pre_idle", idle1);
        @(posedge CLK);
        #5 check("rst_pre_busy", mk(1, 1, 1, 0, 1, 32'h300, 32'h0));
        #1 RST = 1'b1;
        #1 check("rst_abort", idle0);
        bus.ramstate = A;
        #1 check("rst_no_dwait", idle0);
        @(posedge CLK);
        #1 check("rst_held", idle0);
        bus.ramstate = F;
        RST = 1'b0;
        #1 check("rst_release_idle", idle0);
        @(posedge CLK);
        #1 check("rst_first_grant", mk(1, 1, 1, 0, 0, 32'h300, 32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
